// File: rtl/sd_spi_initializer_if.sv
// Host/card-side signal bundle for the SD SPI initializer.
// master = initializer side, slave = host + card side.
interface sd_spi_initializer_if;
   logic       start;
   logic       MISO;
   logic       CS;
   logic       MOSI;
   logic       busy;
   logic       init_done;
   logic       init_error;
   logic [2:0] error_code;
   logic [7:0] r1_out;

   modport master (
      input  start, MISO,
      output CS, MOSI, busy, init_done, init_error, error_code, r1_out
   );

   modport slave (
      output start, MISO,
      input  CS, MOSI, busy, init_done, init_error, error_code, r1_out
   );
endinterface

// File: rtl/sd_spi_initializer.sv
// SD card SPI-mode bring-up: CMD0 -> CMD8 -> (CMD55/ACMD41)* on SCLK, then hands the bus off.
// Per command: 48 send + response wait + 8/40 capture + GAP_CYCLES + 1 check clocks.
module sd_spi_initializer #(
   parameter int DUMMY_CYCLES   = 80,
   parameter int GAP_CYCLES     = 8,
   parameter int RESP_TIMEOUT   = 64,
   parameter int CMD0_RETRIES   = 8,
   parameter int ACMD41_RETRIES = 255
) (
   input  logic                  SCLK,
   input  logic                  reset,
   sd_spi_initializer_if.master  bus
);
   localparam int M1 = (DUMMY_CYCLES > RESP_TIMEOUT) ? DUMMY_CYCLES : RESP_TIMEOUT;
   localparam int M2 = (M1 > 48) ? M1 : 48;
   localparam int M3 = (M2 > GAP_CYCLES) ? M2 : GAP_CYCLES;
   localparam int CW_RAW = $clog2(M3 + 1);
   localparam int CW = (CW_RAW < 8) ? 8 : CW_RAW;

   localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] TOUT_LAST  = CW'(RESP_TIMEOUT - 1);
   localparam logic [CW-1:0] SEND_LAST  = CW'(47);
   localparam logic [CW-1:0] R1_LAST    = CW'(7);
   localparam logic [CW-1:0] R7_LAST    = CW'(39);

   localparam logic [2:0] E_CMD0    = 3'd1;
   localparam logic [2:0] E_CMD8    = 3'd2;
   localparam logic [2:0] E_CMD55   = 3'd3;
   localparam logic [2:0] E_ACMD41  = 3'd4;
   localparam logic [2:0] E_TIMEOUT = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_POWERUP, S_SEND, S_RESP, S_GAP, S_CHECK, S_DONE, S_ERROR
   } state_t;

   typedef enum logic [1:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41} cmd_t;

   state_t        state, state_nxt;
   cmd_t          cmd, cmd_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          capturing, capturing_nxt;
   logic          timed_out, timed_out_nxt;
   logic [10:0]   sh, sh_nxt;
   logic [11:0]   shift_in;
   logic [11:0]   r7_low, r7_nxt;
   logic [7:0]    r1, r1_nxt;
   logic [7:0]    cmd0_tries, cmd0_nxt;
   logic [7:0]    acmd_tries, acmd_nxt;
   logic [8:0]    cmd0_inc, acmd_inc;
   logic          done_q, done_nxt;
   logic          err_q, err_nxt;
   logic [2:0]    code_q, code_nxt;
   logic          cs_c, mosi_c;
   logic [47:0]   frame;
   logic [5:0]    bit_idx;

   always_comb begin
      frame = 48'h40_00000000_95;
      unique case (cmd)
         C_CMD0:   frame = 48'h40_00000000_95;
         C_CMD8:   frame = 48'h48_000001AA_87;
         C_CMD55:  frame = 48'h77_00000000_65;
         C_ACMD41: frame = 48'h69_40000000_77;
      endcase
   end

   assign bit_idx  = 6'd47 - cnt[5:0];
   assign cmd0_inc = {1'b0, cmd0_tries} + 9'd1;
   assign acmd_inc = {1'b0, acmd_tries} + 9'd1;

   always_ff @(posedge SCLK or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         cmd        <= C_CMD0;
         cnt        <= '0;
         capturing  <= 1'b0;
         timed_out  <= 1'b0;
         sh         <= '0;
         r7_low     <= '0;
         r1         <= 8'hFF;
         cmd0_tries <= '0;
         acmd_tries <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= '0;
      end else begin
         state      <= state_nxt;
         cmd        <= cmd_nxt;
         cnt        <= cnt_nxt;
         capturing  <= capturing_nxt;
         timed_out  <= timed_out_nxt;
         sh         <= sh_nxt;
         r7_low     <= r7_nxt;
         r1         <= r1_nxt;
         cmd0_tries <= cmd0_nxt;
         acmd_tries <= acmd_nxt;
         done_q     <= done_nxt;
         err_q      <= err_nxt;
         code_q     <= code_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cmd_nxt       = cmd;
      cnt_nxt       = cnt;
      capturing_nxt = capturing;
      timed_out_nxt = timed_out;
      sh_nxt        = sh;
      r7_nxt        = r7_low;
      r1_nxt        = r1;
      cmd0_nxt      = cmd0_tries;
      acmd_nxt      = acmd_tries;
      done_nxt      = done_q;
      err_nxt       = err_q;
      code_nxt      = code_q;
      cs_c          = 1'b1;
      mosi_c        = 1'b1;
      shift_in      = {sh, bus.MISO};

      unique case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (bus.start) begin
               state_nxt = S_POWERUP;
               cmd_nxt   = C_CMD0;
               cnt_nxt   = '0;
               done_nxt  = 1'b0;
               err_nxt   = 1'b0;
               code_nxt  = '0;
               cmd0_nxt  = '0;
               acmd_nxt  = '0;
            end
         end
         S_POWERUP: begin
            if (cnt == DUMMY_LAST) begin
               state_nxt = S_SEND;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_SEND: begin
            cs_c   = 1'b0;
            mosi_c = frame[bit_idx];
            if (cnt == SEND_LAST) begin
               state_nxt     = S_RESP;
               cnt_nxt       = '0;
               capturing_nxt = 1'b0;
               timed_out_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_RESP: begin
            cs_c = 1'b0;
            // cnt counts wait clocks until the start bit, then captured bits
            if (!capturing) begin
               if (!bus.MISO) begin
                  capturing_nxt = 1'b1;
                  sh_nxt        = shift_in[10:0];
                  cnt_nxt       = CW'(1);
               end else if (cnt == TOUT_LAST) begin
                  cnt_nxt = '0;
                  if (cmd == C_CMD0) begin
                     timed_out_nxt = 1'b1;
                     state_nxt     = S_GAP;
                  end else begin
                     state_nxt = S_ERROR;
                     err_nxt   = 1'b1;
                     code_nxt  = E_TIMEOUT;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end else begin
               sh_nxt  = shift_in[10:0];
               cnt_nxt = cnt + 1'b1;
               if (cnt == R1_LAST) r1_nxt = shift_in[7:0];
               if (cnt == R7_LAST) r7_nxt = shift_in;
               if ((cnt == R1_LAST && cmd != C_CMD8) || cnt == R7_LAST) begin
                  state_nxt = S_GAP;
                  cnt_nxt   = '0;
               end
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = S_CHECK;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_CHECK: begin
            state_nxt = S_SEND;
            cnt_nxt   = '0;
            unique case (cmd)
               C_CMD0: begin
                  if (!timed_out && r1 == 8'h01) begin
                     cmd_nxt = C_CMD8;
                  end else begin
                     cmd0_nxt = cmd0_inc[7:0];
                     if (cmd0_inc >= 9'(CMD0_RETRIES)) begin
                        state_nxt = S_ERROR;
                        err_nxt   = 1'b1;
                        code_nxt  = E_CMD0;
                     end
                  end
               end
               C_CMD8: begin
                  if (r1 == 8'h01 && r7_low == 12'h1AA) begin
                     cmd_nxt = C_CMD55;
                  end else begin
                     state_nxt = S_ERROR;
                     err_nxt   = 1'b1;
                     code_nxt  = E_CMD8;
                  end
               end
               C_CMD55: begin
                  if (r1 == 8'h00 || r1 == 8'h01) begin
                     cmd_nxt = C_ACMD41;
                  end else begin
                     state_nxt = S_ERROR;
                     err_nxt   = 1'b1;
                     code_nxt  = E_CMD55;
                  end
               end
               C_ACMD41: begin
                  if (r1 == 8'h00) begin
                     state_nxt = S_DONE;
                     done_nxt  = 1'b1;
                  end else if (r1 == 8'h01 && acmd_inc < 9'(ACMD41_RETRIES)) begin
                     acmd_nxt = acmd_inc[7:0];
                     cmd_nxt  = C_CMD55;
                  end else begin
                     if (r1 == 8'h01) acmd_nxt = acmd_inc[7:0];
                     state_nxt = S_ERROR;
                     err_nxt   = 1'b1;
                     code_nxt  = E_ACMD41;
                  end
               end
            endcase
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.CS         = cs_c;
   assign bus.MOSI       = mosi_c;
   assign bus.busy       = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign bus.init_done  = done_q;
   assign bus.init_error = err_q;
   assign bus.error_code = code_q;
   assign bus.r1_out     = r1;
endmodule

// File: tb/tb_sd_spi_initializer.sv
// Bench for sd_spi_initializer: a behavioural SD card answers commands from a table;
// each sequence's expected outcome is queued and checked when busy drops.
module tb_sd_spi_initializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sd_spi_initializer_if b ();

   sd_spi_initializer #(.ACMD41_RETRIES(3)) dut (
      .SCLK  (clk),
      .reset (rst),
      .bus   (b)
   );

   typedef struct {
      string      name;
      logic       done;
      logic       err;
      logic [2:0] code;
      logic [7:0] r1;
      int         cycles;
      int         n_cmd0;
      int         n_acmd41;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;

   // card configuration, indexed CMD0, CMD8, CMD55, ACMD41
   bit         en[4];
   logic [7:0] rr[4];
   int         wt[4];
   int         ok_after;

   // card observations
   int          n_cmd[4];
   logic [47:0] first_frame;
   bit          got_first;
   int          pu_cnt;
   bit          seen_lo;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
   endtask

   task automatic bound_fail(input string name);
      n_total++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic cfg(input bit e0, input logic [7:0] r0, input int w0,
                      input bit e1, input logic [7:0] r1, input int w1,
                      input bit e2, input logic [7:0] r2, input int w2,
                      input bit e3, input logic [7:0] r3, input int w3, input int okn);
      en[0] = e0; rr[0] = r0; wt[0] = w0;
      en[1] = e1; rr[1] = r1; wt[1] = w1;
      en[2] = e2; rr[2] = r2; wt[2] = w2;
      en[3] = e3; rr[3] = r3; wt[3] = w3;
      ok_after = okn;
   endtask

   task automatic clear_stats();
      for (int i = 0; i < 4; i++) n_cmd[i] = 0;
      first_frame = '0;
      got_first = 1'b0;
      pu_cnt = 0;
      seen_lo = 1'b0;
   endtask

   task automatic check_reset(input string p);
      chk({p, "_cs"}, 64'(b.CS), 64'd1);
      chk({p, "_mosi"}, 64'(b.MOSI), 64'd1);
      chk({p, "_busy"}, 64'(b.busy), 64'd0);
      chk({p, "_done"}, 64'(b.init_done), 64'd0);
      chk({p, "_err"}, 64'(b.init_error), 64'd0);
      chk({p, "_code"}, 64'(b.error_code), 64'd0);
      chk({p, "_r1"}, 64'(b.r1_out), 64'hFF);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // SD card model: shifts in 48-bit frames while CS is low, then replays a queued response
   initial begin
      logic [47:0] sh;
      logic        q[$];
      int          nb;
      bit          responding;
      int          idx;
      logic [7:0]  r;
      logic [31:0] pl;
      sh = '0; nb = 0; responding = 1'b0;
      b.MISO = 1'b1;
      forever begin
         @(negedge clk);
         if (b.busy && !seen_lo) begin
            if (!b.CS) seen_lo = 1'b1;
            else if (b.MOSI) pu_cnt++;
         end
         if (b.CS) begin
            nb = 0; responding = 1'b0; q.delete();
            b.MISO = 1'b1;
         end else if (responding) begin
            b.MISO = (q.size() != 0) ? q.pop_front() : 1'b1;
         end else begin
            sh = {sh[46:0], b.MOSI};
            nb++;
            b.MISO = 1'b1;
            if (nb == 48) begin
               responding = 1'b1;
               if (!got_first) begin
                  first_frame = sh;
                  got_first = 1'b1;
               end
               case (sh[47:40])
                  8'h40:   idx = 0;
                  8'h48:   idx = 1;
                  8'h77:   idx = 2;
                  8'h69:   idx = 3;
                  default: idx = -1;
               endcase
               if (idx >= 0) begin
                  n_cmd[idx]++;
                  if (en[idx]) begin
                     r = rr[idx];
                     if (idx == 3 && ok_after >= 0 && n_cmd[3] > ok_after) r = 8'h00;
                     for (int i = 0; i < wt[idx]; i++) q.push_back(1'b1);
                     for (int i = 7; i >= 0; i--) q.push_back(r[i]);
                     if (idx == 1 && r == 8'h01) begin
                        pl = 32'h0000_01AA;
                        for (int i = 31; i >= 0; i--) q.push_back(pl[i]);
                     end
                  end
               end
            end
         end
      end
   end

   // Monitor: a busy falling edge ends a sequence; pop and compare its expectation
   initial begin
      bit   prev_busy;
      int   t_start;
      exp_t e;
      prev_busy = 1'b0;
      t_start = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_busy = 1'b0;
         end else begin
            if (!prev_busy && b.busy) t_start = cyc;
            if (prev_busy && !b.busy) begin
               if (exp_q.size() == 0) begin
                  bound_fail("unexpected_end");
               end else begin
                  e = exp_q.pop_front();
                  chk({e.name, "_done"}, 64'(b.init_done), 64'(e.done));
                  chk({e.name, "_err"}, 64'(b.init_error), 64'(e.err));
                  chk({e.name, "_code"}, 64'(b.error_code), 64'(e.code));
                  chk({e.name, "_r1"}, 64'(b.r1_out), 64'(e.r1));
                  chk({e.name, "_cycles"}, 64'(cyc - t_start), 64'(e.cycles));
                  chk({e.name, "_ncmd0"}, 64'(n_cmd[0]), 64'(e.n_cmd0));
                  chk({e.name, "_nacmd41"}, 64'(n_cmd[3]), 64'(e.n_acmd41));
                  chk({e.name, "_frame0"}, 64'(first_frame), 64'h4000_0000_0095);
                  chk({e.name, "_powerup"}, 64'(pu_cnt), 64'd80);
                  chk({e.name, "_release"}, 64'({b.CS, b.MOSI}), 64'b11);
               end
            end
            prev_busy = b.busy;
         end
      end
   end

   task automatic run_scn(input exp_t e, input bit spurious);
      int k;
      exp_q.push_back(e);
      clear_stats();
      @(negedge clk); b.start = 1'b1;
      @(negedge clk); b.start = 1'b0;
      chk({e.name, "_start_busy"}, 64'(b.busy), 64'd1);
      chk({e.name, "_start_clr"}, 64'({b.init_done, b.init_error, b.error_code}), 64'd0);
      k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         @(negedge clk);
         k++;
         b.start = (spurious && k == 200);
      end
      b.start = 1'b0;
      if (exp_q.size() != 0) begin
         bound_fail(e.name);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int k;
      b.start = 1'b0;
      clear_stats();
      cfg(1, 8'h01, 0, 1, 8'h01, 3, 1, 8'h01, 1, 1, 8'h01, 1, 2);
      rst = 1'b1;
      #12;
      check_reset("por");
      @(negedge clk); #2 rst = 1'b0;

      // abort mid-CMD8: reset must force outputs back immediately
      @(negedge clk); b.start = 1'b1;
      @(negedge clk); b.start = 1'b0;
      k = 0;
      while (n_cmd[1] == 0 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (n_cmd[1] == 0) bound_fail("abort_wait_cmd8");
      @(negedge clk); #2 rst = 1'b1;
      #1 check_reset("abort");
      @(negedge clk); @(negedge clk); #2 rst = 1'b0;

      // no card: 8 CMD0 tries of 48 + 64 timeout + 8 gap + 1 check, after 80 dummies
      cfg(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, -1);
      run_scn('{"nocard", 1'b0, 1'b1, 3'd1, 8'hFF, 1048, 8, 0}, 1'b0);

      // ideal card from ERROR, stray start mid-run: 80 + 65 + 100 + 3*66 + 3*66
      cfg(1, 8'h01, 0, 1, 8'h01, 3, 1, 8'h01, 1, 1, 8'h01, 1, 2);
      run_scn('{"ideal", 1'b1, 1'b0, 3'd0, 8'h00, 641, 1, 3}, 1'b1);

      // v1 card rejects CMD8: 80 + 65 + (48 + 2 + 40 + 9)
      cfg(1, 8'h01, 0, 1, 8'h05, 2, 1, 8'h01, 1, 1, 8'h01, 1, -1);
      run_scn('{"v1card", 1'b0, 1'b1, 3'd2, 8'h05, 244, 1, 0}, 1'b0);

      // ACMD41 never leaves idle: three pairs, then code 4
      cfg(1, 8'h01, 0, 1, 8'h01, 3, 1, 8'h01, 1, 1, 8'h01, 1, -1);
      run_scn('{"acmdbusy", 1'b0, 1'b1, 3'd4, 8'h01, 641, 1, 3}, 1'b0);

      // CMD55 unanswered: error straight from the 64-clock wait, 80 + 65 + 100 + 112
      cfg(1, 8'h01, 0, 1, 8'h01, 3, 0, 8'h00, 0, 1, 8'h01, 1, -1);
      run_scn('{"cmd55tout", 1'b0, 1'b1, 3'd5, 8'h01, 357, 1, 0}, 1'b0);

      // CMD55 answered with illegal command: 80 + 65 + 100 + 66
      cfg(1, 8'h01, 0, 1, 8'h01, 3, 1, 8'h05, 1, 1, 8'h01, 1, -1);
      run_scn('{"cmd55bad", 1'b0, 1'b1, 3'd3, 8'h05, 311, 1, 0}, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
